// File: rtl/pc_pkg.sv
// Shared definitions for the 65C02 program-counter byte units.
package pc_pkg;

    typedef enum logic [1:0] {
        PCL_IDLE = 2'd0,
        PCL_REQ  = 2'd1,
        PCL_ACK  = 2'd2
    } pcl_state_t;

    localparam logic [1:0] PC_REQ_NONE   = 2'd0;
    localparam logic [1:0] PC_REQ_CARRY  = 2'd1;
    localparam logic [1:0] PC_REQ_BORROW = 2'd2;

    localparam logic [7:0] PCL_RESET_DEFAULT = 8'h00;

endpackage

// File: rtl/pcl_adder.sv
// Combinational PCL adder for increment and branch displacement.
// Reports carry out of bit 7, or borrow below zero for a negative signed operand.
module pcl_adder (
    input  logic [7:0] pcl,
    input  logic [7:0] operand,
    input  logic       signed_mode,
    output logic [7:0] result,
    output logic       carry,
    output logic       borrow
);

    logic [8:0] sum;

    always_comb begin
        sum    = {1'b0, pcl} + {1'b0, operand};
        result = sum[7:0];
        // A negative operand is operand-256, so no carry out means the result went below zero.
        if (signed_mode && operand[7]) begin
            carry  = 1'b0;
            borrow = ~sum[8];
        end else begin
            carry  = sum[8];
            borrow = 1'b0;
        end
    end

endmodule

// File: rtl/pcl_carry_source.sv
// 65C02 PCL register and requesting end of the four-phase PC carry handshake.
// Define PCL_BORROW_EN for signed branch offsets and borrow requests.
module pcl_carry_source
    import pc_pkg::*;
#(
    parameter logic [7:0] RESET_PCL = PCL_RESET_DEFAULT
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic       instruction_decode_in,
    input  logic       pc_inc,
    input  logic       branch_take,
    input  logic [7:0] branch_offset,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic [7:0] address_low_out,
    output logic       carry_to_pch,
    output logic       borrow_to_pch,
    input  logic       carry_done,
    output logic       pcl_ready
);

`ifdef PCL_BORROW_EN
    localparam logic SIGNED_OFFSET = 1'b1;
`else
    localparam logic SIGNED_OFFSET = 1'b0;
`endif

    pcl_state_t state_q, state_d;
    logic [7:0] pcl_q, pcl_d;
    logic       carry_q, carry_d;
    logic       borrow_q, borrow_d;
    logic       ready_q, ready_d;

    logic [7:0] operand;
    logic [7:0] add_result;
    logic       add_carry;
    logic       add_borrow;
    logic [1:0] req_kind;

    assign operand = branch_take ? branch_offset : 8'h01;

    pcl_adder u_adder (
        .pcl         (pcl_q),
        .operand     (operand),
        .signed_mode (SIGNED_OFFSET),
        .result      (add_result),
        .carry       (add_carry),
        .borrow      (add_borrow)
    );

    always_comb begin
        state_d  = state_q;
        pcl_d    = pcl_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        req_kind = PC_REQ_NONE;

        unique case (state_q)
            PCL_IDLE: begin
                if (instruction_decode_in) begin
                    pcl_d = db_in;
                end else if (branch_take || pc_inc) begin
                    pcl_d = add_result;
                    if (add_carry) begin
                        req_kind = PC_REQ_CARRY;
                    end else if (add_borrow) begin
                        req_kind = PC_REQ_BORROW;
                    end
                    if (req_kind != PC_REQ_NONE) begin
                        state_d = PCL_REQ;
                    end
                    carry_d  = (req_kind == PC_REQ_CARRY);
                    borrow_d = (req_kind == PC_REQ_BORROW);
                end
            end
            PCL_REQ: begin
                if (carry_done) begin
                    state_d  = PCL_ACK;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                end
            end
            PCL_ACK: begin
                if (!carry_done) begin
                    state_d = PCL_IDLE;
                end
            end
            default: begin
                state_d  = PCL_IDLE;
                carry_d  = 1'b0;
                borrow_d = 1'b0;
            end
        endcase

        ready_d = (state_d == PCL_IDLE);
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q  <= PCL_IDLE;
            pcl_q    <= RESET_PCL;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pcl_q    <= pcl_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ready_q  <= ready_d;
        end
    end

    assign db_out          = pcl_q;
    assign address_low_out = pcl_q;
    assign carry_to_pch    = carry_q;
    assign borrow_to_pch   = borrow_q;
    assign pcl_ready       = ready_q;

endmodule
